// File: rtl/dtcm_lsu_if.sv
// Request/response and DTCM-side bus for the dtcm_lsu load/store front-end.
// The slave modport is the LSU's view; master is the CPU/DTCM-facing environment.
interface dtcm_lsu_if #(
  parameter int ADDR_WIDTH   = 12,
  parameter int IO_MAP_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [IO_MAP_WIDTH-1:0] req_wdata;

  logic                    rsp_valid;
  logic [IO_MAP_WIDTH-1:0] rsp_rdata;
  logic                    rsp_err;

  logic [ADDR_WIDTH-1:0]   dtcm_addr;
  logic [IO_MAP_WIDTH-1:0] dtcm_wdata;
  logic                    dtcm_rw;
  logic [IO_MAP_WIDTH-1:0] dtcm_rdata;
  logic                    dtcm_ready;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  dtcm_rdata, dtcm_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dtcm_addr, dtcm_wdata, dtcm_rw
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output dtcm_rdata, dtcm_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dtcm_addr, dtcm_wdata, dtcm_rw
  );
endinterface

// File: rtl/dtcm_lsu.sv
// Load/store front-end for the data TCM: alignment checks, sub-word stores via
// read-modify-write (the DTCM has no byte enables) and load lane extraction/extension.
module dtcm_lsu #(
  parameter int ADDR_WIDTH   = 12,
  parameter int IO_MAP_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  dtcm_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_WAIT,
    STORE,
    RMW_RD,
    RMW_WAIT,
    RMW_WR,
    RESP
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic        misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Little-endian lane select followed by sign/zero extension.
  function automatic logic [IO_MAP_WIDTH-1:0] extend_load(
    input logic [IO_MAP_WIDTH-1:0] w,
    input logic [1:0]              lane,
    input logic [1:0]              size,
    input logic                    uns
  );
    logic [7:0]              b;
    logic [15:0]             h;
    logic [IO_MAP_WIDTH-1:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{(IO_MAP_WIDTH-8){b[7] & ~uns}}, b};
      2'b01:   r = {{(IO_MAP_WIDTH-16){h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [IO_MAP_WIDTH-1:0] merge_store(
    input logic [IO_MAP_WIDTH-1:0] w,
    input logic [1:0]              lane,
    input logic [1:0]              size,
    input logic [15:0]             d
  );
    logic [IO_MAP_WIDTH-1:0] r;
    r = w;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      size_q         <= '0;
      lane_q         <= '0;
      uns_q          <= 1'b0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.dtcm_rw    <= 1'b0;
      bus.dtcm_addr  <= '0;
      bus.dtcm_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            size_q        <= bus.req_size;
            lane_q        <= bus.req_addr[1:0];
            uns_q         <= bus.req_unsigned;
            wdata_q       <= bus.req_wdata[15:0];
            bus.req_ready <= 1'b0;
            if (misaligned) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              bus.dtcm_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (!bus.req_we) begin
                state <= LOAD;
              end else if (bus.req_size == 2'b10) begin
                state          <= STORE;
                bus.dtcm_rw    <= 1'b1;
                bus.dtcm_wdata <= bus.req_wdata;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        LOAD:   state <= LOAD_WAIT;
        RMW_RD: state <= RMW_WAIT;
        LOAD_WAIT: begin
          if (bus.dtcm_ready) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= extend_load(bus.dtcm_rdata, lane_q, size_q, uns_q);
          end
        end
        RMW_WAIT: begin
          if (bus.dtcm_ready) begin
            state          <= RMW_WR;
            bus.dtcm_rw    <= 1'b1;
            bus.dtcm_wdata <= merge_store(bus.dtcm_rdata, lane_q, size_q, wdata_q);
          end
        end
        STORE, RMW_WR: begin
          state         <= RESP;
          bus.dtcm_rw   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
        end
        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtcm_lsu.sv
// Scoreboard bench for dtcm_lsu: a byte-array reference memory predicts every
// response; a separate monitor checks data, error, latency and write count.
module tb_dtcm_lsu;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  bit   prev_rsp;
  int   wr_cnt;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  refm [0:4095];
  logic [31:0] dmem [0:1023] = '{default: '0};
  logic [31:0] rdq;

  dtcm_lsu_if #(.ADDR_WIDTH(12), .IO_MAP_WIDTH(32)) bus ();

  dtcm_lsu #(.ADDR_WIDTH(12), .IO_MAP_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DTCM behaviour: one-cycle registered read, write on dtcm_rw; garbage when not ready.
  always @(posedge clk) begin
    if (bus.dtcm_rw) dmem[bus.dtcm_addr[11:2]] <= bus.dtcm_wdata;
    rdq <= dmem[bus.dtcm_addr[11:2]];
  end
  assign bus.dtcm_rdata = bus.dtcm_ready ? rdq : 32'hDEAD_BEEF;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: memory as bytes, accesses as byte counts and plain arithmetic.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [11:0] addr, input logic [31:0] wdata,
                            input int k, output exp_t e);
    int n;
    int a;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a = int'(addr);
    e.rdata = '0;
    e.err   = 1'b0;
    e.wr    = 0;
    e.lat   = 0;
    e.acc   = 0;
    if (size == 2'd3 || (a % n) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) refm[a + i] = wdata[8*i +: 8];
      e.wr  = 1;
      e.lat = (n == 4) ? 2 : 4 + k;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(refm[a + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      e.rdata = v;
      e.lat   = 3 + k;
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  // k = cycles dtcm_ready is held low while the LSU waits for read data.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata, input int k);
    exp_t e;
    wait_ready();
    if (!bus.req_ready) return;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bus.req_addr  = 12'($urandom);
    ref_access(we, size, uns, addr, wdata, k, e);
    e.acc = cyc;
    q.push_back(e);
    if (k > 0) begin
      bus.dtcm_ready = 1'b0;
      repeat (k + 1) @(posedge clk);
      #1 bus.dtcm_ready = 1'b1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (prev_rsp) chk("req_ready_after_resp", 32'(bus.req_ready), 32'd1);
      prev_rsp = bus.rsp_valid;
      if (bus.dtcm_rw) begin
        if (q.size() == 0) chk("stray_write", 32'(bus.dtcm_rw), 32'd0);
        else wr_cnt++;
      end
      if (q.size() != 0) chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("write_count", 32'(wr_cnt), 32'(e.wr));
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] w;
    cyc = 0; checks = 0; errors = 0; mon_en = 0; prev_rsp = 0; wr_cnt = 0;
    for (int i = 0; i < 4096; i++) refm[i] = 8'h00;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.dtcm_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_dtcm_rw", 32'(bus.dtcm_rw), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_dtcm_addr", 32'(bus.dtcm_addr), 32'd0);
    chk("reset_dtcm_wdata", bus.dtcm_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
    mon_en = 1;

    issue(1'b1, 2'd2, 1'b0, 12'h100, 32'hABCDEF12, 0);
    issue(1'b0, 2'd2, 1'b0, 12'h100, 32'h0, 0);
    issue(1'b1, 2'd2, 1'b0, 12'h100, 32'h11223344, 0);
    issue(1'b1, 2'd0, 1'b0, 12'h102, 32'hFFFFFF5A, 0);
    issue(1'b0, 2'd2, 1'b0, 12'h100, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b1, 12'h102, 32'h0, 0);
    issue(1'b1, 2'd0, 1'b0, 12'h103, 32'h00000080, 1);
    issue(1'b0, 2'd0, 1'b0, 12'h103, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b1, 12'h103, 32'h0, 2);
    issue(1'b1, 2'd1, 1'b0, 12'h202, 32'h1234BEEF, 0);
    issue(1'b0, 2'd2, 1'b0, 12'h200, 32'h0, 0);
    issue(1'b0, 2'd1, 1'b0, 12'h202, 32'h0, 0);
    issue(1'b0, 2'd1, 1'b1, 12'h202, 32'h0, 0);
    issue(1'b0, 2'd2, 1'b0, 12'h101, 32'h0, 0);
    issue(1'b1, 2'd1, 1'b0, 12'h203, 32'hCAFE5555, 0);
    issue(1'b1, 2'd3, 1'b0, 12'h000, 32'h99999999, 0);
    issue(1'b0, 2'd2, 1'b0, 12'h200, 32'h0, 0);
    issue(1'b1, 2'd2, 1'b0, 12'hFFC, 32'hAABBCCDD, 0);
    issue(1'b0, 2'd2, 1'b0, 12'hFFC, 32'h0, 3);
    issue(1'b0, 2'd1, 1'b0, 12'hFFE, 32'h0, 1);

    // Reset while a byte store sits in its read-wait; the write must never happen.
    issue(1'b1, 2'd2, 1'b0, 12'h100, 32'h11223344, 0);
    drain();
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_addr = 12'h100; bus.req_wdata = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.dtcm_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midreset_dtcm_rw", 32'(bus.dtcm_rw), 32'd0);
    chk("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    bus.dtcm_ready = 1'b1;
    @(negedge clk);
    chk("midreset_req_ready_rise", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 12'h100, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 1) == 0) ? 12'h100 : 12'hFE0;
      a = a + 12'($urandom_range(0, 31));
      w = $urandom;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    drain();

    for (int i = 0; i < 1024; i++) begin
      chk("final_memory", dmem[i],
          {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
